// File: rtl/vga_protocol_gen_if.sv
// rtl/vga_protocol_gen_if.sv - VGA output bundle (sync, active-video qualifier, RGB, DAC clock)
interface vga_if;
    logic       h_sync;
    logic       v_sync;
    logic       disp_vld;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_clk;

    modport master (
        output h_sync,
        output v_sync,
        output disp_vld,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_clk
    );

    modport slave (
        input h_sync,
        input v_sync,
        input disp_vld,
        input vga_r,
        input vga_g,
        input vga_b,
        input vga_clk
    );
endinterface

// File: rtl/vga_protocol_gen.sv
// rtl/vga_protocol_gen.sv - VGA 640x480@60 timing generator with colour-bar test pattern
module vga_protocol_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    vga_if.master vga
);

    localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_VIS_START = H_SYNC + H_BACK;
    localparam int H_VIS_END   = H_VIS_START + H_ACTIVE;
    localparam int V_VIS_START = V_SYNC + V_BACK;
    localparam int V_VIS_END   = V_VIS_START + V_ACTIVE;
    localparam int BAR_W       = 80;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);

    // ST_IDLE holds the counters at (0,0) for one edge after reset release so
    // the frame restarts cleanly; the first decoded pixel appears one edge later.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          disp_vld_q, disp_vld_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [7:0]    b_q, b_d;
    logic [HW-1:0] x;
    logic [2:0]    bar;

    // Next-state: counter advance and registered decode of the current position
    always_comb begin
        state_d    = state_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        h_sync_d   = 1'b1;
        v_sync_d   = 1'b1;
        disp_vld_d = 1'b0;
        r_d        = 8'h00;
        g_d        = 8'h00;
        b_d        = 8'h00;
        x          = '0;
        bar        = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (h_cnt_q == HW'(H_TOTAL - 1)) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
                h_sync_d   = (h_cnt_q >= HW'(H_SYNC));
                v_sync_d   = (v_cnt_q >= VW'(V_SYNC));
                disp_vld_d = (h_cnt_q >= HW'(H_VIS_START)) && (h_cnt_q < HW'(H_VIS_END)) &&
                             (v_cnt_q >= VW'(V_VIS_START)) && (v_cnt_q < VW'(V_VIS_END));
                x   = h_cnt_q - HW'(H_VIS_START);
                bar = 3'(x / HW'(BAR_W));
                // Bar colours map directly onto bar-index bits: red off for
                // bars 2,3,6,7, green off for 4..7, blue off for odd bars.
                if (disp_vld_d) begin
                    r_d = bar[1] ? 8'h00 : 8'hFF;
                    g_d = bar[2] ? 8'h00 : 8'hFF;
                    b_d = bar[0] ? 8'h00 : 8'hFF;
                end
            end
        endcase
    end

    // State, counters and output registers; reset drives idle output levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            h_sync_q   <= 1'b1;
            v_sync_q   <= 1'b1;
            disp_vld_q <= 1'b0;
            r_q        <= 8'h00;
            g_q        <= 8'h00;
            b_q        <= 8'h00;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            h_sync_q   <= h_sync_d;
            v_sync_q   <= v_sync_d;
            disp_vld_q <= disp_vld_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    // DAC samples mid-pixel, so it gets the inverted pixel clock
    assign vga.vga_clk  = ~clk;
    assign vga.h_sync   = h_sync_q;
    assign vga.v_sync   = v_sync_q;
    assign vga.disp_vld = disp_vld_q;
    assign vga.vga_r    = r_q;
    assign vga.vga_g    = g_q;
    assign vga.vga_b    = b_q;

endmodule

// File: tb/tb_vga_protocol_gen.sv
// tb/tb_vga_protocol_gen.sv - self-checking bench for vga_protocol_gen against a cycle-count model
module tb_vga_protocol_gen;

    // Full horizontal timing; shortened vertical timing keeps whole frames affordable.
    localparam int HS = 96, HB = 48, HA = 640, HF = 16;
    localparam int VS = 2, VB = 3, VA = 6, VF = 2;
    localparam int H_TOT = HS + HB + HA + HF;
    localparam int V_TOT = VS + VB + VA + VF;
    localparam int FRAME = H_TOT * V_TOT;
    localparam logic [26:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 24'h000000};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   k;
    logic [23:0] bars [8];

    vga_if vga ();

    vga_protocol_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vga)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Rising edges seen since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    function automatic logic [26:0] observed();
        return {vga.h_sync, vga.v_sync, vga.disp_vld, vga.vga_r, vga.vga_g, vga.vga_b};
    endfunction

    // Expected outputs after kk edges: edge 1 restarts at (0,0), edge 2 shows pixel (0,0).
    function automatic logic [26:0] expected(input int kk);
        int p, h, v;
        logic hs, vs, dv;
        logic [23:0] rgb;
        if (kk < 2) return RESET_VEC;
        p   = kk - 2;
        h   = p % H_TOT;
        v   = (p / H_TOT) % V_TOT;
        hs  = (h >= HS);
        vs  = (v >= VS);
        dv  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        rgb = dv ? bars[(h - (HS + HB)) / 80] : 24'h000000;
        return {hs, vs, dv, rgb};
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check("pixel", 32'(observed()), 32'(expected(k)));
            check("vga_clk_hi", 32'(vga.vga_clk), 32'd1);
        end
    endtask

    initial begin
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;

        repeat (4) begin
            @(negedge clk);
            check("reset_vals", 32'(observed()), 32'(RESET_VEC));
            check("vga_clk_hi", 32'(vga.vga_clk), 32'd1);
            @(posedge clk);
            #1;
            check("vga_clk_lo", 32'(vga.vga_clk), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(2 * FRAME + 100);

        // Random mid-frame resets: outputs must drop to reset values asynchronously
        for (int i = 0; i < 3; i++) begin
            run($urandom_range(300, 8000));
            @(posedge clk);
            #7;
            rst_n = 1'b0;
            #1;
            check("async_reset", 32'(observed()), 32'(RESET_VEC));
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check("reset_hold", 32'(observed()), 32'(RESET_VEC));
            end
            rst_n = 1'b1;
        end

        @(posedge clk);
        #1;
        check("edge1_hsync_idle", 32'(vga.h_sync), 32'd1);
        @(posedge clk);
        #1;
        check("edge2_hsync_low", 32'(vga.h_sync), 32'd0);
        check("edge2_vsync_low", 32'(vga.v_sync), 32'd0);
        run(FRAME + 900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
